apb_top: RTL and testbench
==========================

// Module: apb_top
// PURPOSE
//  APB slave endpoint: word-addressed internal memory behind an APB-style
//  setup/access handshake. Driven by an APB master (the test driver) and
//  returns read data, a ready strobe and an error flag. One clock domain.
//  Fixed one wait state per transfer; protocol and address errors are flagged.
// PARAMETERS
//  ADDR_WIDTH  8   width of PADDR (word address, no byte lanes)
//  DATA_WIDTH  32  width of PWDATA / m_rdata
//  MEM_DEPTH   64  implemented words; PADDR >= MEM_DEPTH is out of range
// PORTS
//  PCLK     in   1           clock, all logic on rising edge
//  PRESETn  in   1           synchronous reset, ACTIVE-HIGH (despite name)
//  PWRITE   in   1           1=write, 0=read; sampled in setup phase
//  PSELx    in   1           slave select
//  PENABLE  in   1           access-phase indicator
//  PADDR    in   ADDR_WIDTH  word address; sampled in setup phase
//  PWDATA   in   DATA_WIDTH  write data; sampled in setup phase
//  m_rdata  out  DATA_WIDTH  read data, registered
//  m_ready  out  1           transfer-complete strobe (1 cycle), registered
//  m_error  out  1           error qualifier, valid only while m_ready=1
// BEHAVIOUR
//  Reset (PRESETn=1 at edge): state=IDLE; m_rdata=0, m_ready=0, m_error=0;
//   all memory words cleared to 0. Reset wins over any in-flight transfer;
//   an interrupted transfer is dropped with no write.
//  FSM states IDLE, SETUP, ACCESS (registered; outputs from registers only).
//  IDLE:  PSELx=1,PENABLE=0 -> SETUP; latch PADDR, PWRITE, PWDATA.
//         PSELx=1,PENABLE=1 (no setup) -> ACCESS flagged protocol error.
//         else stay IDLE.
//  SETUP: PSELx=1,PENABLE=1 -> ACCESS; perform op using LATCHED values.
//         PSELx=1,PENABLE=0 -> stay SETUP, re-latch PADDR/PWRITE/PWDATA.
//         PSELx=0 -> IDLE (abort, no write, no response).
//  ACCESS: m_ready=1 for exactly this cycle; always -> IDLE next edge.
//  Op on SETUP->ACCESS edge:
//   addr < MEM_DEPTH, write: mem[addr]<=wdata; m_error=0; m_rdata held.
//   addr < MEM_DEPTH, read : m_rdata<=mem[addr]; m_error=0.
//   addr >= MEM_DEPTH: no write; reads load m_rdata=0; m_error=1.
//   protocol error (IDLE->ACCESS): no access; m_rdata held; m_error=1.
//  Timing: setup sampled at edge E0, PENABLE sampled at E1, m_ready/m_error/
//   m_rdata valid in cycle after E1; master holds PSELx/PENABLE through it.
//   Min transfer 3 cycles; next setup may start the cycle m_ready is high
//   (sampled at E2 while state=ACCESS is ignored; must re-present in IDLE).
//  m_ready, m_error return to 0 in IDLE/SETUP; m_rdata holds last value.
//  Read-after-write to same address returns newly written data.
// STRUCTURE
//  apb_pkg: state_t enum {IDLE,SETUP,ACCESS}; default width/depth constants.
//  Sub-module apb_mem: MEM_DEPTH x DATA_WIDTH register array, 1 write port,
//   1 read port, synchronous clear on reset. apb_top holds FSM + latches.
// TESTING
//  Reset: PRESETn=1 two cycles -> m_rdata=0,m_ready=0,m_error=0; read addr 5 -> 0.
//  Write 0xDEADBEEF @0x05 then read @0x05 -> m_ready pulse, m_rdata=0xDEADBEEF,
//   m_error=0.
//  Write @0x40 (>=64) -> m_error=1 with m_ready; later read @0x40 -> m_rdata=0,
//   m_error=1; mem unchanged (read @0x00 still prior value).
//  PENABLE=1 with PSELx=1 from IDLE -> one-cycle m_ready=1,m_error=1, no write.
//  PSELx dropped after setup of write 0x1234 @0x03 -> no m_ready, mem[3] unchanged.
//  Back-to-back writes @0..3 (0x11..0x44), reset asserted mid-write @3 ->
//   all outputs 0, all words read back 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default geometry for the APB slave endpoint.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MEM_DEPTH_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_mem.sv
// Word register array with one write port, one combinational read port
// and synchronous clear.
module apb_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_top.sv
// APB slave endpoint: setup/access handshake in front of apb_mem, with
// one fixed wait state and protocol/address error reporting.
module apb_top
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PWRITE,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_ready,
  output logic                  m_error
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  in_range;

  assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

  apb_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk  (PCLK),
    .rst  (PRESETn),
    .we   (mem_we),
    .waddr(addr_q[IDX_W-1:0]),
    .wdata(wdata_q),
    .raddr(addr_q[IDX_W-1:0]),
    .rdata(mem_rdata)
  );

  // Next-state, latch and response logic; responses only ever leave via flops.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (PSELx && !PENABLE) begin
          state_d = SETUP;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
        end else if (PSELx && PENABLE) begin
          state_d = ACCESS;
          ready_d = 1'b1;
          error_d = 1'b1;
        end
      end
      SETUP: begin
        if (!PSELx) begin
          state_d = IDLE;
        end else if (!PENABLE) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
        end else begin
          state_d = ACCESS;
          ready_d = 1'b1;
          if (!in_range) begin
            error_d = 1'b1;
            if (!write_q) begin
              rdata_d = '0;
            end
          end else if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end
      end
      ACCESS: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign m_rdata = rdata_q;
  assign m_ready = ready_q;
  assign m_error = error_q;

endmodule

// File: tb/tb_apb_top.sv
// Directed bench for apb_top: reset, read/write, range and protocol errors,
// aborted setup, setup re-latch and reset during a transfer.
module tb_apb_top;

  logic        PCLK;
  logic        PRESETn;
  logic        PWRITE;
  logic        PSELx;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        m_error;

  int tests;
  int failures;

  apb_top dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PWRITE (PWRITE),
    .PSELx  (PSELx),
    .PENABLE(PENABLE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .m_rdata(m_rdata),
    .m_ready(m_ready),
    .m_error(m_error)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Full three-cycle transfer; returns the response seen during the ACCESS cycle.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic rdy, output logic err);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    step();
    PENABLE = 1'b1;
    step();
    rd = m_rdata; rdy = m_ready; err = m_error;
    PSELx = 1'b0; PENABLE = 1'b0;
    step();
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic rdy, err;
    PRESETn = 1'b1;
    step(); step();
    chk32("reset_rdata", m_rdata, 32'h0);
    chk1("reset_ready", m_ready, 1'b0);
    chk1("reset_error", m_error, 1'b0);
    PRESETn = 1'b0;
    step();
    xfer(1'b0, 8'h05, 32'h0, rd, rdy, err);
    chk32("reset_read5_data", rd, 32'h0);
    chk1("reset_read5_ready", rdy, 1'b1);
    chk1("reset_read5_error", err, 1'b0);
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic rdy, err;
    xfer(1'b1, 8'h05, 32'hDEADBEEF, rd, rdy, err);
    chk1("wr5_ready", rdy, 1'b1);
    chk1("wr5_error", err, 1'b0);
    chk32("wr5_rdata_held", rd, 32'h0);
    chk1("wr5_ready_drops", m_ready, 1'b0);
    xfer(1'b0, 8'h05, 32'h0, rd, rdy, err);
    chk32("rd5_data", rd, 32'hDEADBEEF);
    chk1("rd5_ready", rdy, 1'b1);
    chk1("rd5_error", err, 1'b0);
    chk32("rd5_rdata_holds_idle", m_rdata, 32'hDEADBEEF);
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic rdy, err;
    xfer(1'b1, 8'h00, 32'hCAFE0000, rd, rdy, err);
    xfer(1'b1, 8'h40, 32'h5555AAAA, rd, rdy, err);
    chk1("oor_wr_ready", rdy, 1'b1);
    chk1("oor_wr_error", err, 1'b1);
    chk1("oor_error_drops", m_error, 1'b0);
    xfer(1'b0, 8'h40, 32'h0, rd, rdy, err);
    chk32("oor_rd_data", rd, 32'h0);
    chk1("oor_rd_error", err, 1'b1);
    xfer(1'b0, 8'hFF, 32'h0, rd, rdy, err);
    chk1("oor_rd_ff_error", err, 1'b1);
    xfer(1'b0, 8'h00, 32'h0, rd, rdy, err);
    chk32("oor_mem0_intact", rd, 32'hCAFE0000);
    chk1("oor_mem0_error", err, 1'b0);
    xfer(1'b0, 8'h3F, 32'h0, rd, rdy, err);
    chk1("last_word_in_range", err, 1'b0);
  endtask

  task automatic test_protocol_error();
    logic [31:0] rd; logic rdy, err;
    xfer(1'b0, 8'h00, 32'h0, rd, rdy, err);
    PSELx = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h00000BAD;
    step();
    chk1("proto_ready", m_ready, 1'b1);
    chk1("proto_error", m_error, 1'b1);
    chk32("proto_rdata_held", m_rdata, 32'hCAFE0000);
    PSELx = 1'b0; PENABLE = 1'b0;
    step();
    chk1("proto_ready_drops", m_ready, 1'b0);
    xfer(1'b0, 8'h00, 32'h0, rd, rdy, err);
    chk32("proto_no_write", rd, 32'hCAFE0000);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic rdy, err;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 32'h00001234;
    step();
    PSELx = 1'b0;
    step();
    chk1("abort_no_ready", m_ready, 1'b0);
    step();
    chk1("abort_still_no_ready", m_ready, 1'b0);
    xfer(1'b0, 8'h03, 32'h0, rd, rdy, err);
    chk32("abort_mem3", rd, 32'h0);
  endtask

  task automatic test_relatch();
    logic [31:0] rd; logic rdy, err;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h00000088;
    step();
    PADDR = 8'h07; PWDATA = 32'h00000077;
    step();
    chk1("relatch_wait_no_ready", m_ready, 1'b0);
    PENABLE = 1'b1;
    step();
    chk1("relatch_ready", m_ready, 1'b1);
    PSELx = 1'b0; PENABLE = 1'b0;
    step();
    xfer(1'b0, 8'h07, 32'h0, rd, rdy, err);
    chk32("relatch_mem7", rd, 32'h00000077);
    xfer(1'b0, 8'h08, 32'h0, rd, rdy, err);
    chk32("relatch_mem8", rd, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic rdy, err;
    xfer(1'b1, 8'h00, 32'h11, rd, rdy, err);
    xfer(1'b1, 8'h01, 32'h22, rd, rdy, err);
    xfer(1'b1, 8'h02, 32'h33, rd, rdy, err);
    xfer(1'b0, 8'h01, 32'h0, rd, rdy, err);
    chk32("b2b_rd1", rd, 32'h22);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h03; PWDATA = 32'h44;
    step();
    PENABLE = 1'b1; PRESETn = 1'b1;
    step();
    chk1("midrst_ready", m_ready, 1'b0);
    chk1("midrst_error", m_error, 1'b0);
    chk32("midrst_rdata", m_rdata, 32'h0);
    PSELx = 1'b0; PENABLE = 1'b0;
    step();
    PRESETn = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 8'(i), 32'h0, rd, rdy, err);
      chk32($sformatf("midrst_mem%0d", i), rd, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; failures = 0;
    PRESETn = 1'b1; PWRITE = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    PADDR = 8'h0; PWDATA = 32'h0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_protocol_error();
    test_abort();
    test_relatch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
